// File: rtl/sample_bram_buffer.sv
// Sample block buffer: captures DEPTH samples from the UART receiver into block RAM,
// then streams them out over valid/ready, single-shot or looped.
module sample_bram_buffer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_datavalid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_play,
    input  logic              i_loop,
    input  logic              i_clear,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overrun,
    output logic [ADDR_W:0]   o_count
);

    typedef enum logic [1:0] {
        S_CAPTURE,
        S_FULL,
        S_PLAY
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    state_t state, state_nxt;

    logic signed [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0]        wr_addr;
    logic [ADDR_W-1:0]        rd_addr_p0;
    logic [ADDR_W-1:0]        out_idx;
    logic                     vld_p1;
    logic signed [DATA_W-1:0] rd_data_p1;
    logic                     skid_vld_p2;
    logic signed [DATA_W-1:0] skid_data_p2;

    logic       wr_en, rd_en, play_start, capture_last, stop_evt, drop;
    logic       xfer, last_xfer, out_load, take_skid, take_p1, skid_load;
    logic [1:0] occ;

    assign xfer      = o_valid && i_ready;
    assign last_xfer = xfer && (out_idx == LAST_ADDR);
    assign out_load  = !o_valid || xfer;
    assign take_skid = out_load && skid_vld_p2;
    assign take_p1   = out_load && !skid_vld_p2 && vld_p1;
    // p1 parks in the skid when the output register is busy, or refills it behind a skid drain
    assign skid_load = vld_p1 && (skid_vld_p2 == out_load);
    // Entries held after this edge; a new read may issue only if one slot stays free
    assign occ = {1'b0, o_valid} + {1'b0, skid_vld_p2} + {1'b0, vld_p1} - {1'b0, xfer};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_CAPTURE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        play_start   = 1'b0;
        capture_last = 1'b0;
        stop_evt     = 1'b0;
        drop         = 1'b0;
        case (state)
            S_CAPTURE: begin
                if (i_datavalid) begin
                    wr_en = 1'b1;
                    if (wr_addr == LAST_ADDR) begin
                        capture_last = 1'b1;
                        state_nxt    = S_FULL;
                    end
                end
            end
            S_FULL: begin
                drop = i_datavalid;
                if (i_play) begin
                    play_start = 1'b1;
                    state_nxt  = S_PLAY;
                end
            end
            S_PLAY: begin
                drop  = i_datavalid;
                rd_en = (occ < 2'd2);
                // Reads run ahead across the wrap; a single-shot end flushes the prefetch
                if (last_xfer && !i_loop) begin
                    stop_evt  = 1'b1;
                    rd_en     = 1'b0;
                    state_nxt = S_CAPTURE;
                end
            end
            default: state_nxt = S_CAPTURE;
        endcase
        if (i_clear) begin
            state_nxt    = S_CAPTURE;
            wr_en        = 1'b0;
            rd_en        = 1'b0;
            play_start   = 1'b0;
            capture_last = 1'b0;
            stop_evt     = 1'b0;
            drop         = 1'b0;
        end
    end

    // p0: memory write / read issue
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= $signed(i_data);
        end
        if (rd_en) begin
            rd_data_p1 <= mem[rd_addr_p0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            wr_addr     <= '0;
            rd_addr_p0  <= '0;
            out_idx     <= '0;
            o_count     <= '0;
            o_full      <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_overrun   <= 1'b0;
            vld_p1      <= 1'b0;
            o_valid     <= 1'b0;
            skid_vld_p2 <= 1'b0;
        end else begin
            o_done <= stop_evt;
            if (drop) begin
                o_overrun <= 1'b1;
            end
            if (wr_en) begin
                wr_addr <= wr_addr + ADDR_ONE;
                o_count <= o_count + CNT_ONE;
            end
            if (capture_last) begin
                o_full <= 1'b1;
            end
            if (play_start) begin
                rd_addr_p0 <= '0;
                out_idx    <= '0;
                o_busy     <= 1'b1;
            end
            if (rd_en) begin
                rd_addr_p0 <= rd_addr_p0 + ADDR_ONE;
            end
            if (xfer) begin
                out_idx <= out_idx + ADDR_ONE;
            end

            // p1 -> p2: output register and skid occupancy
            vld_p1 <= rd_en;
            if (out_load) begin
                o_valid     <= skid_vld_p2 || vld_p1;
                skid_vld_p2 <= skid_vld_p2 && vld_p1;
            end else begin
                skid_vld_p2 <= skid_vld_p2 || vld_p1;
            end

            if (stop_evt) begin
                o_valid     <= 1'b0;
                skid_vld_p2 <= 1'b0;
                vld_p1      <= 1'b0;
                wr_addr     <= '0;
                out_idx     <= '0;
                o_count     <= '0;
                o_full      <= 1'b0;
                o_busy      <= 1'b0;
            end
        end
    end

    // p2: output data, drawn from the skid first to preserve order
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data <= '0;
        end else if (take_skid) begin
            o_data <= skid_data_p2;
        end else if (take_p1) begin
            o_data <= rd_data_p1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (skid_load) begin
            skid_data_p2 <= rd_data_p1;
        end
    end

endmodule

// File: tb/tb_sample_bram_buffer.sv
// Directed bench for sample_bram_buffer with a 4-entry block: capture, playback,
// backpressure, looping, overrun, clear and reset.
module tb_sample_bram_buffer;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst, datavalid, play, loop_en, clear, ready;
    logic [DATA_W-1:0] data;
    logic              o_valid, o_full, o_busy, o_done, o_overrun;
    logic [DATA_W-1:0] o_data;
    logic [ADDR_W:0]   o_count;

    int checks = 0;
    int errors = 0;

    logic [15:0] smp [4];
    bit          pat [20] = '{1,0,0,1,0,1,1,0,1,0,0,1,1,0,1,0,1,1,0,1};

    always #5 clk = ~clk;

    sample_bram_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_datavalid(datavalid), .i_data(data),
        .i_play(play), .i_loop(loop_en), .i_clear(clear), .i_ready(ready),
        .o_valid(o_valid), .o_data(o_data), .o_full(o_full), .o_busy(o_busy),
        .o_done(o_done), .o_overrun(o_overrun), .o_count(o_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic capture();
        for (int i = 0; i < 4; i++) begin
            datavalid = 1'b1;
            data      = smp[i];
            tick();
        end
        datavalid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"},   o_valid,   0);
        chk({tag, "_data"},    o_data,    0);
        chk({tag, "_full"},    o_full,    0);
        chk({tag, "_busy"},    o_busy,    0);
        chk({tag, "_done"},    o_done,    0);
        chk({tag, "_overrun"}, o_overrun, 0);
        chk({tag, "_count"},   o_count,   0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          idx;
        logic        prev_stall;
        logic [15:0] prev_data;

        rst = 1'b1; datavalid = 1'b0; play = 1'b0; loop_en = 1'b0;
        clear = 1'b0; ready = 1'b0; data = '0;
        tick();
        tick();
        chk_reset_outputs("rst");
        rst = 1'b0;

        // Capture; i_play arrives together with the final write and must be ignored
        smp = '{16'h0AB1, 16'h1279, 16'hBEEF, 16'h0001};
        for (int i = 0; i < 4; i++) begin
            datavalid = 1'b1;
            data      = smp[i];
            play      = (i == 3);
            tick();
            chk("cap_count", o_count, i + 1);
            chk("cap_full", o_full, (i == 3));
        end
        datavalid = 1'b0;
        play      = 1'b0;
        repeat (3) begin
            tick();
            chk("play_ign_busy", o_busy, 0);
            chk("play_ign_valid", o_valid, 0);
        end

        // Sample while full is dropped
        datavalid = 1'b1;
        data      = 16'hDEAD;
        tick();
        datavalid = 1'b0;
        chk("ovr_flag", o_overrun, 1);
        chk("ovr_count", o_count, 4);
        chk("ovr_full", o_full, 1);

        // Single-shot playback
        ready = 1'b1; loop_en = 1'b0; play = 1'b1;
        tick();
        play = 1'b0;
        chk("ss_busy", o_busy, 1);
        chk("ss_lat1_valid", o_valid, 0);
        tick();
        chk("ss_lat2_valid", o_valid, 0);
        for (int b = 0; b < 4; b++) begin
            tick();
            chk("ss_valid", o_valid, 1);
            chk("ss_data", o_data, smp[b]);
            chk("ss_nodone", o_done, 0);
        end
        tick();
        chk("ss_done", o_done, 1);
        chk("ss_end_valid", o_valid, 0);
        chk("ss_end_busy", o_busy, 0);
        tick();
        chk("ss_done_pulse", o_done, 0);
        chk("ss_full", o_full, 0);
        chk("ss_count", o_count, 0);
        chk("ss_ovr_kept", o_overrun, 1);

        // Backpressure
        capture();
        play = 1'b1;
        tick();
        play       = 1'b0;
        idx        = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int k = 0; k < 40 && idx < 4; k++) begin
            if (prev_stall) begin
                chk("bp_stall_valid", o_valid, 1);
                chk("bp_stall_data", o_data, prev_data);
            end
            ready = pat[k % 20];
            if (o_valid) chk("bp_data", o_data, smp[idx]);
            prev_stall = o_valid && !ready;
            prev_data  = o_data;
            if (o_valid && ready) idx++;
            tick();
        end
        chk("bp_delivered", idx, 4);
        chk("bp_done", o_done, 1);
        ready = 1'b1;
        tick();
        chk("bp_after_valid", o_valid, 0);

        // Looped playback across the wrap, then clear while running
        capture();
        loop_en = 1'b1;
        play    = 1'b1;
        tick();
        play = 1'b0;
        tick();
        for (int b = 0; b < 10; b++) begin
            tick();
            chk("loop_valid", o_valid, 1);
            chk("loop_data", o_data, smp[b % 4]);
            chk("loop_nodone", o_done, 0);
        end
        clear     = 1'b1;
        datavalid = 1'b1;
        data      = 16'h5555;
        tick();
        clear     = 1'b0;
        datavalid = 1'b0;
        loop_en   = 1'b0;
        chk("clr_valid", o_valid, 0);
        chk("clr_busy", o_busy, 0);
        chk("clr_full", o_full, 0);
        chk("clr_count", o_count, 0);
        chk("clr_overrun", o_overrun, 0);
        chk("clr_nodone", o_done, 0);
        tick();
        chk("clr_nodone2", o_done, 0);
        chk("clr_valid2", o_valid, 0);
        chk("clr_count2", o_count, 0);

        // Recapture after clear lands at address 0
        smp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        capture();
        chk("rcap_full", o_full, 1);
        chk("rcap_count", o_count, 4);
        play = 1'b1;
        tick();
        play = 1'b0;
        tick();
        for (int b = 0; b < 4; b++) begin
            tick();
            chk("rcap_valid", o_valid, 1);
            chk("rcap_data", o_data, smp[b]);
        end
        tick();
        chk("rcap_done", o_done, 1);

        // Reset in the middle of playback
        capture();
        play = 1'b1;
        tick();
        play = 1'b0;
        tick();
        tick();
        chk("mrst_beat0", o_data, smp[0]);
        tick();
        chk("mrst_beat1", o_data, smp[1]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs("mrst");
        tick();
        chk("mrst_valid_after", o_valid, 0);
        chk("mrst_busy_after", o_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
